// File: rtl/top.sv
// DCIM macro top: signed weight array with a bit-serial activation dot product.
// Optional `DCIM_SIGNED_INPUT_EN` treats activations as two's complement (MSB plane subtracted).
module top #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned WW    = 4,
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = WW + IN_W + $clog2(ROWS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [$clog2(ROWS)-1:0]  wr_addr,
  input  logic [WW-1:0]            wr_data,
  input  logic                     start,
  input  logic [ROWS*IN_W-1:0]     x_in,
  output logic [OUT_W-1:0]         nout,
  output logic                     st,
  output logic                     busy
);

  localparam int unsigned BW = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COMP = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                   state_q;
  logic [WW-1:0]            w_q  [ROWS];
  logic [WW-1:0]            wc_q [ROWS];
  logic [IN_W-1:0]          x_q  [ROWS];
  logic [BW-1:0]            bit_q;
  logic                     last_c;
  logic signed [OUT_W-1:0]  acc_q;
  logic signed [OUT_W-1:0]  partial_d;
  logic signed [OUT_W-1:0]  term_d;
  logic signed [OUT_W-1:0]  acc_d;

  assign last_c = (bit_q == BW'(IN_W - 1));

  // One bit-plane: sum of sign-extended snapshot weights whose activation bit is set.
  always_comb begin
    partial_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (x_q[r][bit_q]) begin
        partial_d = partial_d + {{(OUT_W - WW){wc_q[r][WW-1]}}, wc_q[r]};
      end
    end
    term_d = partial_d <<< bit_q;
`ifdef DCIM_SIGNED_INPUT_EN
    acc_d = last_c ? (acc_q - term_d) : (acc_q + term_d);
`else
    acc_d = acc_q + term_d;
`endif
  end

  // Weights are snapshotted at start so a same-cycle write cannot leak into that compute.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      acc_q   <= '0;
      nout    <= '0;
      st      <= 1'b0;
      busy    <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        w_q[r]  <= '0;
        wc_q[r] <= '0;
        x_q[r]  <= '0;
      end
    end else begin
      st <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_en) begin
            w_q[wr_addr] <= wr_data;
          end
          if (start) begin
            wc_q <= w_q;
            for (int r = 0; r < ROWS; r++) begin
              x_q[r] <= x_in[r*IN_W +: IN_W];
            end
            acc_q   <= '0;
            bit_q   <= '0;
            busy    <= 1'b1;
            state_q <= S_COMP;
          end
        end
        S_COMP: begin
          acc_q <= acc_d;
          bit_q <= bit_q + BW'(1);
          if (last_c) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          nout    <= acc_q;
          st      <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the DCIM top: directed cases plus random dot products
// checked against an integer multiply-accumulate model.
module tb_top;

  localparam int ROWS  = 16;
  localparam int WW    = 4;
  localparam int IN_W  = 4;
  localparam int OUT_W = 12;
  localparam int LAT   = IN_W + 1;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b1;
  logic                   wr_en = 1'b0;
  logic [3:0]             wr_addr = '0;
  logic [WW-1:0]          wr_data = '0;
  logic                   start = 1'b0;
  logic [ROWS*IN_W-1:0]   x_in = '0;
  logic [OUT_W-1:0]       nout;
  logic                   st;
  logic                   busy;

  int n_checks = 0;
  int n_fail   = 0;
  int w_m [ROWS];

  top dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .x_in    (x_in),
    .nout    (nout),
    .st      (st),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OUT_W-1:0] dot(input logic [ROWS*IN_W-1:0] xv);
    int s = 0;
    for (int r = 0; r < ROWS; r++) begin
      logic [IN_W-1:0] xr;
      int xi;
      xr = xv[r*IN_W +: IN_W];
`ifdef DCIM_SIGNED_INPUT_EN
      xi = int'($signed(xr));
`else
      xi = int'(xr);
`endif
      s += w_m[r] * xi;
    end
    return OUT_W'(s);
  endfunction

  function automatic logic [ROWS*IN_W-1:0] fill_x(input logic [IN_W-1:0] v);
    logic [ROWS*IN_W-1:0] xv;
    for (int r = 0; r < ROWS; r++) xv[r*IN_W +: IN_W] = v;
    return xv;
  endfunction

  task automatic wr(input int addr, input int val);
    wr_addr = 4'(addr);
    wr_data = WW'(val);
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    w_m[addr] = val;
  endtask

  task automatic launch(input logic [ROWS*IN_W-1:0] xv);
    x_in  = xv;
    start = 1'b1;
    tick();
    start = 1'b0;
    x_in  = '0;
  endtask

  // Waits (bounded) for st; lat is the number of edges still expected.
  task automatic wait_done(input string tag, input logic [OUT_W-1:0] exp, input int lat);
    int n = 0;
    while (st !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_nout"}, 32'(nout), 32'(exp));
    check({tag, "_busy_at_st"}, 32'(busy), 32'd0);
  endtask

  task automatic after_done(input string tag, input logic [OUT_W-1:0] exp);
    tick();
    check({tag, "_st_once"}, 32'(st), 32'd0);
    check({tag, "_hold"}, 32'(nout), 32'(exp));
  endtask

  task automatic run(input string tag, input logic [ROWS*IN_W-1:0] xv);
    logic [OUT_W-1:0] e;
    e = dot(xv);
    launch(xv);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag, e, LAT);
    after_done(tag, e);
  endtask

  initial begin
    logic [ROWS*IN_W-1:0] xv, xv2;
    logic [OUT_W-1:0] e, e2;
    for (int r = 0; r < ROWS; r++) w_m[r] = 0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_nout", 32'(nout), 32'd0);
      check("rst_st", 32'(st), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    rstn = 1'b0;
    tick();
    run("zero_w", {$urandom, $urandom});

    // Unit case
    for (int r = 0; r < ROWS; r++) wr(r, 1);
    xv = fill_x(4'h1);
    check("unit_model", 32'(dot(xv)), 32'h010);
    run("unit", xv);

    // Extreme
    for (int r = 0; r < ROWS; r++) wr(r, -8);
    xv = fill_x(4'hF);
`ifdef DCIM_SIGNED_INPUT_EN
    check("extreme_model", 32'(dot(xv)), 32'h080);
`else
    check("extreme_model", 32'(dot(xv)), 32'h880);
`endif
    run("extreme", xv);

    // Mixed, with start and wr_en injected mid-compute
    for (int r = 0; r < ROWS; r++) wr(r, r - 8);
    xv = '0;
    xv[3:0]   = 4'd3;
    xv[63:60] = 4'd2;
    e = dot(xv);
    check("mixed_model", 32'(e), 32'hFF6);
    launch(xv);
    tick();
    tick();
    start = 1'b1; x_in = fill_x(4'h7);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'd5;
    tick();
    start = 1'b0; x_in = '0; wr_en = 1'b0;
    wait_done("mixed", e, LAT - 3);
    after_done("mixed", e);
    run("mixed_again", xv);

    // Same-cycle start and write: compute uses the old weight
    xv = fill_x(4'h5);
    e  = dot(xv);
    x_in = xv; start = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'd7;
    tick();
    start = 1'b0; wr_en = 1'b0; x_in = '0;
    w_m[2] = 7;
    wait_done("same_cyc", e, LAT);
    after_done("same_cyc", e);
    run("same_cyc_new", xv);

    // Back-to-back: next start issued in the st cycle
    xv  = {$urandom, $urandom};
    xv2 = {$urandom, $urandom};
    e   = dot(xv);
    e2  = dot(xv2);
    launch(xv);
    wait_done("b2b_a", e, LAT);
    launch(xv2);
    check("b2b_st_drop", 32'(st), 32'd0);
    wait_done("b2b_b", e2, LAT);
    after_done("b2b_b", e2);

    // Random weights and activations
    for (int t = 0; t < 24; t++) begin
      int nw;
      nw = int'($urandom_range(4));
      for (int k = 0; k < nw; k++) wr(int'($urandom_range(15)), int'($urandom_range(15)) - 8);
      run("rand", {$urandom, $urandom});
    end

    // Reset mid-compute
    launch(fill_x(4'hF));
    tick();
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    for (int r = 0; r < ROWS; r++) w_m[r] = 0;
    check("midrst_nout", 32'(nout), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("midrst_no_st", 32'(st), 32'd0);
      tick();
    end
    run("post_rst", fill_x(4'hF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
